// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bus between two CPU cores and the shared-bus arbiter
// Per core n (0/1), core -> arbiter:
//     grant_request_n  request the bus
//     rw_n             1 = write, 0 = read
//     address_n[8:0]   bit 8 selects the GPIO window
//     wdata_n[7:0]     write data
// Arbiter -> cores:
//     grant_given_n    one-cycle completion strobe
//     rdata[7:0]       shared read data, valid while either grant_given is high
// Modports: master = core side, slave = arbiter side.
interface bus_arbiter_if;
    logic       grant_request_0;
    logic       rw_0;
    logic [8:0] address_0;
    logic [7:0] wdata_0;
    logic       grant_given_0;
    logic       grant_request_1;
    logic       rw_1;
    logic [8:0] address_1;
    logic [7:0] wdata_1;
    logic       grant_given_1;
    logic [7:0] rdata;
    modport master (
        output grant_request_0, rw_0, address_0, wdata_0,
        output grant_request_1, rw_1, address_1, wdata_1,
        input  grant_given_0, grant_given_1, rdata
    );
    modport slave (
        input  grant_request_0, rw_0, address_0, wdata_0,
        input  grant_request_1, rw_1, address_1, wdata_1,
        output grant_given_0, grant_given_1, rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for two cores in front of a 256-byte RAM and a GPIO window
module bus_arbiter #(
  parameter int    MEM_DEPTH = 256,
  parameter string MEM_INIT  = ""
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus,
  input  logic [7:0]   gpio_in,
  output logic [7:0]   gpio_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, GRANT, HOLD} state_t;
  state_t     r_state;
  state_t     w_next;
  logic       r_owner;
  logic       r_last_owner;
  logic       r_rw;
  logic       r_gnt0;
  logic       r_gnt1;
  logic [8:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic [7:0] r_gpio_out;
  logic [7:0] r_mem [MEM_DEPTH];
  logic [7:0] w_gpio_rd;
  logic [7:0] w_rd_val;
  logic       w_latch;
  logic       w_pick;
  logic       w_access;
  logic       w_mem_we;
`ifdef GPIO_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_gpio_rd = r_sync2;
`else
  assign w_gpio_rd = gpio_in;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE   ? ((bus.grant_request_0 || bus.grant_request_1) ? ACCESS : IDLE) :
             r_state == ACCESS ? GRANT :
             r_state == GRANT  ? HOLD : IDLE;
  end
  always_comb begin
    w_latch  = (r_state == IDLE) && (bus.grant_request_0 || bus.grant_request_1);
    w_pick   = (bus.grant_request_0 && bus.grant_request_1) ? ~r_last_owner : bus.grant_request_1;
    w_access = (r_state == ACCESS);
    w_mem_we = w_access && r_rw && !r_addr[8];
    w_rd_val = !r_addr[8]          ? r_mem[r_addr[7:0]] :
               (r_addr == 9'h100) ? r_gpio_out :
               (r_addr == 9'h101) ? w_gpio_rd : 8'h00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_gpio_out   <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
    end else begin
      if (w_latch) begin
        r_owner      <= w_pick;
        r_last_owner <= w_pick;
        r_rw         <= w_pick ? bus.rw_1 : bus.rw_0;
        r_addr       <= w_pick ? bus.address_1 : bus.address_0;
        r_wdata      <= w_pick ? bus.wdata_1 : bus.wdata_0;
      end
      if (w_access) begin
        r_rdata <= r_rw ? 8'h00 : w_rd_val;
        if (r_rw && r_addr == 9'h100) r_gpio_out <= r_wdata;
      end
      r_gnt0 <= w_access && !r_owner;
      r_gnt1 <= w_access && r_owner;
    end
  end
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr[7:0]] <= r_wdata;
  end
  assign bus.grant_given_0 = r_gnt0;
  assign bus.grant_given_1 = r_gnt1;
  assign bus.rdata         = r_rdata;
  assign gpio_out          = r_gpio_out;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector bench for bus_arbiter
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out;

    bus_arbiter_if bif();

    bus_arbiter dut (
        .clk(clk),
        .reset(reset),
        .bus(bif),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rq0;
        logic       rw0;
        logic [8:0] a0;
        logic [7:0] d0;
        logic       rq1;
        logic       rw1;
        logic [8:0] a1;
        logic [7:0] d1;
        logic [7:0] gin;
        logic       win;
        logic [7:0] rd;
        logic [7:0] gpo;
    } vec_t;

    vec_t v [19];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_requests();
        bif.grant_request_0 = 1'b0;
        bif.grant_request_1 = 1'b0;
    endtask

    task automatic check_idle_grants(input string tag);
        check({tag, "_g0"}, {7'b0, bif.grant_given_0}, 8'h00);
        check({tag, "_g1"}, {7'b0, bif.grant_given_1}, 8'h00);
    endtask

    // One full transaction: requests are dropped right after the sampling edge,
    // so every vector also exercises completion of an abandoned request.
    task automatic run_vec(input vec_t x, input string tag);
        bif.grant_request_0 = x.rq0;
        bif.rw_0            = x.rw0;
        bif.address_0       = x.a0;
        bif.wdata_0         = x.d0;
        bif.grant_request_1 = x.rq1;
        bif.rw_1            = x.rw1;
        bif.address_1       = x.a1;
        bif.wdata_1         = x.d1;
        gpio_in             = x.gin;
        tick();
        drop_requests();
        check_idle_grants({tag, "_access"});
        tick();
        check({tag, "_grant_g0"}, {7'b0, bif.grant_given_0}, {7'b0, ~x.win});
        check({tag, "_grant_g1"}, {7'b0, bif.grant_given_1}, {7'b0, x.win});
        check({tag, "_rdata"}, bif.rdata, x.rd);
        check({tag, "_gpio_out"}, gpio_out, x.gpo);
        tick();
        check_idle_grants({tag, "_hold"});
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got no $finish, expected one");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t x;
        logic       e0;
        logic       e1;
        logic [7:0] erd;
        //        rq0 rw0 a0      d0     rq1 rw1 a1      d1     gin    win rd     gpo
        v[0]  = '{1, 1, 9'h005, 8'hA5, 0, 0, 9'h000, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        v[1]  = '{1, 0, 9'h005, 8'h00, 0, 0, 9'h000, 8'h00, 8'h00, 0, 8'hA5, 8'h00};
        v[2]  = '{1, 0, 9'h005, 8'h00, 1, 1, 9'h006, 8'h5B, 8'h00, 1, 8'h00, 8'h00};
        v[3]  = '{1, 0, 9'h006, 8'h00, 1, 0, 9'h005, 8'h00, 8'h00, 0, 8'h5B, 8'h00};
        v[4]  = '{0, 0, 9'h000, 8'h00, 1, 1, 9'h100, 8'h3C, 8'h00, 1, 8'h00, 8'h3C};
        v[5]  = '{1, 0, 9'h100, 8'h00, 0, 0, 9'h000, 8'h00, 8'h81, 0, 8'h3C, 8'h3C};
        v[6]  = '{0, 0, 9'h000, 8'h00, 1, 0, 9'h101, 8'h00, 8'h81, 1, 8'h81, 8'h3C};
        v[7]  = '{1, 1, 9'h101, 8'hFF, 0, 0, 9'h000, 8'h00, 8'h81, 0, 8'h00, 8'h3C};
        v[8]  = '{0, 0, 9'h000, 8'h00, 1, 0, 9'h101, 8'h00, 8'h81, 1, 8'h81, 8'h3C};
        v[9]  = '{1, 1, 9'h1FF, 8'hEE, 0, 0, 9'h000, 8'h00, 8'h81, 0, 8'h00, 8'h3C};
        v[10] = '{0, 0, 9'h000, 8'h00, 1, 0, 9'h1FF, 8'h00, 8'h81, 1, 8'h00, 8'h3C};
        v[11] = '{0, 0, 9'h000, 8'h00, 1, 1, 9'h050, 8'h66, 8'h81, 1, 8'h00, 8'h3C};
        v[12] = '{1, 1, 9'h150, 8'h11, 0, 0, 9'h000, 8'h00, 8'h81, 0, 8'h00, 8'h3C};
        v[13] = '{0, 0, 9'h000, 8'h00, 1, 0, 9'h050, 8'h00, 8'h81, 1, 8'h66, 8'h3C};
        v[14] = '{1, 1, 9'h000, 8'h99, 0, 0, 9'h000, 8'h00, 8'h81, 0, 8'h00, 8'h3C};
        v[15] = '{1, 0, 9'h100, 8'h00, 1, 0, 9'h000, 8'h00, 8'h81, 1, 8'h99, 8'h3C};
        v[16] = '{1, 1, 9'h010, 8'h42, 0, 0, 9'h000, 8'h00, 8'h81, 0, 8'h00, 8'h3C};
        v[17] = '{0, 0, 9'h000, 8'h00, 1, 1, 9'h011, 8'h24, 8'h81, 1, 8'h00, 8'h3C};
        v[18] = '{0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'h11, 8'h81, 1, 8'h00, 8'h3C};

        bif.grant_request_0 = 1'b0;
        bif.rw_0            = 1'b0;
        bif.address_0       = '0;
        bif.wdata_0         = '0;
        bif.grant_request_1 = 1'b0;
        bif.rw_1            = 1'b0;
        bif.address_1       = '0;
        bif.wdata_1         = '0;

        tick();
        tick();
        check_idle_grants("reset");
        check("reset_rdata", bif.rdata, 8'h00);
        check("reset_gpio_out", gpio_out, 8'h00);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) run_vec(v[i], $sformatf("v%0d", i));

        // Both cores hold read requests continuously from reset: grants must alternate
        // 0,1,0,1 with one-cycle pulses spaced four clocks apart.
        pulse_reset();
        bif.grant_request_0 = 1'b1;
        bif.rw_0            = 1'b0;
        bif.address_0       = 9'h010;
        bif.grant_request_1 = 1'b1;
        bif.rw_1            = 1'b0;
        bif.address_1       = 9'h011;
        for (int c = 0; c < 32; c++) begin
            tick();
            e0 = (c % 4 == 1) && ((c / 4) % 2 == 0);
            e1 = (c % 4 == 1) && ((c / 4) % 2 == 1);
            check($sformatf("rr_c%0d_g0", c), {7'b0, bif.grant_given_0}, {7'b0, e0});
            check($sformatf("rr_c%0d_g1", c), {7'b0, bif.grant_given_1}, {7'b0, e1});
            if (c % 4 == 1) check($sformatf("rr_c%0d_rdata", c), bif.rdata, e0 ? 8'h42 : 8'h24);
        end
        drop_requests();
        tick();

        x = '{1, 1, 9'h100, 8'hC3, 0, 0, 9'h000, 8'h00, 8'h81, 0, 8'h00, 8'hC3};
        run_vec(x, "gpio_set");

        // Reset lands inside ACCESS of a RAM write: nothing may commit or grant.
        bif.grant_request_0 = 1'b1;
        bif.rw_0            = 1'b1;
        bif.address_0       = 9'h020;
        bif.wdata_0         = 8'h77;
        tick();
        drop_requests();
        #2;
        reset = 1'b0;
        #1;
        check_idle_grants("abort");
        check("abort_gpio_out", gpio_out, 8'h00);
        check("abort_rdata", bif.rdata, 8'h00);
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_idle_grants($sformatf("post_abort_c%0d", c));
        end
        x = '{0, 0, 9'h000, 8'h00, 1, 0, 9'h020, 8'h00, 8'h81, 1, 8'h11, 8'h00};
        run_vec(x, "abort_ram");

        // gpio_in changes one clock before the ACCESS edge of a 0x101 read.
        gpio_in = 8'h00;
        tick();
        tick();
        tick();
        bif.grant_request_0 = 1'b1;
        bif.rw_0            = 1'b0;
        bif.address_0       = 9'h101;
        tick();
        drop_requests();
        gpio_in = 8'h5A;
        tick();
`ifdef GPIO_SYNC_EN
        erd = 8'h00;
`else
        erd = 8'h5A;
`endif
        check("gin_edge_g0", {7'b0, bif.grant_given_0}, 8'h01);
        check("gin_edge_rdata", bif.rdata, erd);
        tick();
        tick();
        x = '{1, 0, 9'h101, 8'h00, 0, 0, 9'h000, 8'h00, 8'h5A, 0, 8'h5A, 8'h00};
        run_vec(x, "gin_late");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
